// File: rtl/keyvalue_scan_if.sv
// rtl/keyvalue_scan_if.sv - pipelined Wishbone-style bus bundle for keyvalue_scan
interface keyvalue_scan_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16
);
    logic             CYC_i;
    logic             STB_i;
    logic             WE_i;
    logic [15:0]      ADR_i;
    logic [KEY_W-1:0] KEY_i;
    logic [VAL_W-1:0] DAT_i;
    logic             STALL_o;
    logic             ACK_o;
    logic             ERR_o;
    logic             HIT_o;
    logic [VAL_W-1:0] DAT_o;

    modport master (
        output CYC_i, STB_i, WE_i, ADR_i, KEY_i, DAT_i,
        input  STALL_o, ACK_o, ERR_o, HIT_o, DAT_o
    );

    modport slave (
        input  CYC_i, STB_i, WE_i, ADR_i, KEY_i, DAT_i,
        output STALL_o, ACK_o, ERR_o, HIT_o, DAT_o
    );
endinterface

// File: rtl/keyvalue_scan.sv
// rtl/keyvalue_scan.sv - linear-scan key/value store; KEYVALUE_EVICT_EN enables round-robin eviction when full
module keyvalue_scan #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    keyvalue_scan_if.slave   bus,
    output logic [CNT_W-1:0] COUNT_o,
    output logic             FULL_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC, S_ACK} state_t;
    typedef enum logic [1:0] {OP_GET, OP_STATUS, OP_PUT, OP_DEL} op_t;

    state_t           state_q;
    op_t              op_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;
    logic [IDX_W-1:0] idx_q;
    logic             hit_found_q;
    logic             free_found_q;
    logic [IDX_W-1:0] free_idx_q;
    logic [CNT_W-1:0] count_q;
    logic             stall_q;
    logic             ack_q;
    logic             err_q;
    logic             hit_q;
    logic [VAL_W-1:0] dat_q;

    logic             valid_q   [DEPTH];
    logic [KEY_W-1:0] key_mem_q [DEPTH];
    logic [VAL_W-1:0] val_mem_q [DEPTH];

`ifdef KEYVALUE_EVICT_EN
    logic [IDX_W-1:0] rr_q;
`endif

    logic full;
    logic unused_adr;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign unused_adr = ^bus.ADR_i[15:1];

    assign bus.STALL_o = stall_q;
    assign bus.ACK_o   = ack_q;
    assign bus.ERR_o   = err_q;
    assign bus.HIT_o   = hit_q;
    assign bus.DAT_o   = dat_q;
    assign COUNT_o     = count_q;
    assign FULL_o      = full;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_GET;
            key_q        <= '0;
            val_q        <= '0;
            idx_q        <= '0;
            hit_found_q  <= 1'b0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            count_q      <= '0;
            stall_q      <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            hit_q        <= 1'b0;
            dat_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                key_mem_q[i] <= '0;
                val_mem_q[i] <= '0;
            end
`ifdef KEYVALUE_EVICT_EN
            rr_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.CYC_i && bus.STB_i) begin
                        op_q         <= op_t'({bus.WE_i, bus.ADR_i[0]});
                        key_q        <= bus.KEY_i;
                        val_q        <= bus.DAT_i;
                        idx_q        <= '0;
                        hit_found_q  <= 1'b0;
                        free_found_q <= 1'b0;
                        free_idx_q   <= '0;
                        stall_q      <= 1'b1;
                        state_q      <= (!bus.WE_i && bus.ADR_i[0]) ? S_EXEC : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!bus.CYC_i) begin
                        stall_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (valid_q[idx_q] && key_mem_q[idx_q] == key_q) begin
                        // idx_q stays parked on the matching slot for EXEC
                        hit_found_q <= 1'b1;
                        state_q     <= S_EXEC;
                    end else begin
                        if (!valid_q[idx_q] && !free_found_q) begin
                            free_found_q <= 1'b1;
                            free_idx_q   <= idx_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_EXEC;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_EXEC: begin
                    err_q   <= 1'b0;
                    hit_q   <= 1'b0;
                    dat_q   <= '0;
                    ack_q   <= 1'b1;
                    state_q <= S_ACK;
                    case (op_q)
                        OP_STATUS: begin
                            dat_q <= VAL_W'(count_q);
                            hit_q <= full;
                        end
                        OP_GET: begin
                            if (hit_found_q) begin
                                dat_q <= val_mem_q[idx_q];
                                hit_q <= 1'b1;
                            end
                        end
                        OP_DEL: begin
                            if (hit_found_q) begin
                                valid_q[idx_q] <= 1'b0;
                                count_q        <= count_q - CNT_W'(1);
                                dat_q          <= val_mem_q[idx_q];
                                hit_q          <= 1'b1;
                            end
                        end
                        OP_PUT: begin
                            if (hit_found_q) begin
                                val_mem_q[idx_q] <= val_q;
                                dat_q            <= VAL_W'(idx_q);
                                hit_q            <= 1'b1;
                            end else if (free_found_q) begin
                                valid_q[free_idx_q]   <= 1'b1;
                                key_mem_q[free_idx_q] <= key_q;
                                val_mem_q[free_idx_q] <= val_q;
                                count_q               <= count_q + CNT_W'(1);
                                dat_q                 <= VAL_W'(free_idx_q);
                            end else begin
`ifdef KEYVALUE_EVICT_EN
                                key_mem_q[rr_q] <= key_q;
                                val_mem_q[rr_q] <= val_q;
                                dat_q           <= VAL_W'(rr_q);
                                rr_q            <= (rr_q == LAST_IDX) ? '0 : rr_q + IDX_W'(1);
`else
                                err_q <= 1'b1;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
                S_ACK: begin
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keyvalue_scan.sv
// tb/tb_keyvalue_scan.sv - randomized model-checked bench for keyvalue_scan (DEPTH=4), honours KEYVALUE_EVICT_EN
module tb_keyvalue_scan;
    localparam int D = 4;
    localparam int OP_GET = 0, OP_STATUS = 1, OP_PUT = 2, OP_DEL = 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] count_o;
    logic       full_o;

    keyvalue_scan_if #(.KEY_W(16), .VAL_W(16)) bus ();

    keyvalue_scan #(.KEY_W(16), .VAL_W(16), .DEPTH(D)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .COUNT_o (count_o),
        .FULL_o  (full_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          ack_cyc;
        logic        err;
        logic        hit;
        logic [15:0] dat;
        int          count;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   cur_count = 0;

    logic        m_valid [D];
    logic [15:0] m_key   [D];
    logic [15:0] m_val   [D];
    int          m_count;
    int          m_rr;

    int          l_lat;
    logic [15:0] l_dat;
    logic        l_hit;
    logic        l_err;
    int          l_count;
    int          l_full;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_val[i]   = '0;
        end
        m_count = 0;
        m_rr    = 0;
    endtask

    // Expected response and latency straight from the store's rules
    task automatic model_op(input int op, input logic [15:0] k, input logic [15:0] d, output exp_t e);
        int hit_i;
        int free_i;
        hit_i = -1;
        free_i = -1;
        for (int i = 0; i < D; i++) begin
            if (hit_i < 0 && m_valid[i] && m_key[i] == k) hit_i = i;
            if (free_i < 0 && !m_valid[i]) free_i = i;
        end
        e.err = 1'b0;
        e.hit = 1'b0;
        e.dat = '0;
        if (op == OP_STATUS) begin
            e.ack_cyc = 2;
            e.dat     = 16'(m_count);
            e.hit     = (m_count == D);
        end else begin
            e.ack_cyc = (hit_i >= 0) ? 3 + hit_i : D + 2;
            if (op == OP_GET && hit_i >= 0) begin
                e.hit = 1'b1;
                e.dat = m_val[hit_i];
            end else if (op == OP_DEL && hit_i >= 0) begin
                e.hit = 1'b1;
                e.dat = m_val[hit_i];
                m_valid[hit_i] = 1'b0;
                m_count--;
            end else if (op == OP_PUT) begin
                if (hit_i >= 0) begin
                    e.hit = 1'b1;
                    e.dat = 16'(hit_i);
                    m_val[hit_i] = d;
                end else if (free_i >= 0) begin
                    m_valid[free_i] = 1'b1;
                    m_key[free_i]   = k;
                    m_val[free_i]   = d;
                    m_count++;
                    e.dat = 16'(free_i);
                end else begin
`ifdef KEYVALUE_EVICT_EN
                    m_key[m_rr] = k;
                    m_val[m_rr] = d;
                    e.dat = 16'(m_rr);
                    m_rr = (m_rr + 1) % D;
`else
                    e.err = 1'b1;
`endif
                end
            end
        end
        e.count = m_count;
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            cur_count = 0;
        end else begin
            if (bus.ACK_o) begin
                if (q.size() == 0) begin
                    chk("spurious_ack", bus.ACK_o, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.ack_cyc);
                    chk("err", bus.ERR_o, e.err);
                    chk("hit", bus.HIT_o, e.hit);
                    chk("dat", bus.DAT_o, e.dat);
                    cur_count = e.count;
                end
            end else if (q.size() > 0 && cyc > q[0].ack_cyc) begin
                chk("ack_timeout", cyc, q[0].ack_cyc);
                void'(q.pop_front());
            end
            chk("count", count_o, cur_count);
            chk("full", full_o, (cur_count == D));
        end
    end

    task automatic present(input int op, input logic [15:0] k, input logic [15:0] d);
        bus.CYC_i = 1'b1;
        bus.STB_i = 1'b1;
        bus.WE_i  = (op >= OP_PUT);
        bus.ADR_i = 16'(op % 2);
        bus.KEY_i = k;
        bus.DAT_i = d;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following ACK
    task automatic do_op(input int op, input logic [15:0] k, input logic [15:0] d);
        exp_t e;
        int   acc;
        present(op, k, d);
        chk("stall_idle", bus.STALL_o, 0);
        acc = cyc;
        model_op(op, k, d, e);
        e.ack_cyc += acc;
        q.push_back(e);
        @(posedge sys_clk); #1;
        bus.STB_i = 1'b0;
        l_lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (bus.ACK_o) begin
                l_lat   = cyc - acc;
                l_dat   = bus.DAT_o;
                l_hit   = bus.HIT_o;
                l_err   = bus.ERR_o;
                l_count = int'(count_o);
                l_full  = int'(full_o);
                break;
            end
        end
        @(posedge sys_clk); #1;
        bus.CYC_i = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst   = 1'b1;
        bus.CYC_i = 1'b0;
        bus.STB_i = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        q.delete();
        model_clear();
    endtask

    task automatic fill_1_to_4();
        for (int k = 1; k <= 4; k++) do_op(OP_PUT, 16'(k), 16'(16'h0100 + k));
    endtask

    initial begin
        bus.CYC_i = 1'b0;
        bus.STB_i = 1'b0;
        bus.WE_i  = 1'b0;
        bus.ADR_i = '0;
        bus.KEY_i = '0;
        bus.DAT_i = '0;
        model_clear();
        @(posedge sys_clk); #1;
        do_reset();

        chk("rst_stall", bus.STALL_o, 0);
        chk("rst_ack", bus.ACK_o, 0);
        chk("rst_err", bus.ERR_o, 0);
        chk("rst_hit", bus.HIT_o, 0);
        chk("rst_dat", bus.DAT_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_full", full_o, 0);

        do_op(OP_STATUS, 16'h0, 16'h0);
        chk("status_lat", l_lat, 2);
        chk("status_dat", l_dat, 0);
        chk("status_hit", l_hit, 0);

        do_op(OP_PUT, 16'h00AA, 16'h1234);
        chk("put_new_dat", l_dat, 0);
        chk("put_new_hit", l_hit, 0);
        chk("put_new_count", l_count, 1);
        do_op(OP_GET, 16'h00AA, 16'h0);
        chk("get_lat", l_lat, 3);
        chk("get_dat", l_dat, 16'h1234);
        chk("get_hit", l_hit, 1);

        do_op(OP_PUT, 16'h00AA, 16'h5678);
        chk("put_upd_hit", l_hit, 1);
        chk("put_upd_dat", l_dat, 0);
        chk("put_upd_count", l_count, 1);
        do_op(OP_GET, 16'h00AA, 16'h0);
        chk("get_upd_dat", l_dat, 16'h5678);
        do_op(OP_GET, 16'h0BAD, 16'h0);
        chk("miss_lat", l_lat, 6);
        chk("miss_hit", l_hit, 0);
        chk("miss_dat", l_dat, 0);

        do_reset();
        fill_1_to_4();
        do_op(OP_PUT, 16'd5, 16'h0555);
`ifdef KEYVALUE_EVICT_EN
        chk("evict_dat", l_dat, 0);
        chk("evict_err", l_err, 0);
        do_op(OP_GET, 16'd1, 16'h0);
        chk("evicted_get_hit", l_hit, 0);
        do_op(OP_PUT, 16'd6, 16'h0666);
        chk("evict2_dat", l_dat, 1);
`else
        chk("full_err", l_err, 1);
        chk("full_count", l_count, 4);
        chk("full_flag", l_full, 1);
        do_op(OP_STATUS, 16'h0, 16'h0);
        chk("status_full_hit", l_hit, 1);
        chk("status_full_dat", l_dat, 4);
`endif

        do_reset();
        fill_1_to_4();
        do_op(OP_DEL, 16'd2, 16'h0);
        chk("del_dat", l_dat, 16'h0102);
        chk("del_hit", l_hit, 1);
        chk("del_count", l_count, 3);
        do_op(OP_PUT, 16'd9, 16'h0909);
        chk("put_reuse_dat", l_dat, 1);

        // Abort: drop CYC_i in cycle 2 of a GET whose hit would land at slot 3
        present(OP_GET, 16'd4, 16'h0);
        @(posedge sys_clk); #1;
        bus.STB_i = 1'b0;
        @(posedge sys_clk); #1;
        bus.CYC_i = 1'b0;
        @(posedge sys_clk); #1;
        chk("abort_stall", bus.STALL_o, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
        end
        do_op(OP_GET, 16'd4, 16'h0);
        chk("after_abort_hit", l_hit, 1);
        chk("after_abort_lat", l_lat, 6);

        // Reset in the middle of a scan
        present(OP_GET, 16'd4, 16'h0);
        @(posedge sys_clk); #1;
        bus.STB_i = 1'b0;
        @(posedge sys_clk); #1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
        end
        chk("midrst_count", count_o, 0);
        do_op(OP_GET, 16'd4, 16'h0);
        chk("midrst_get_hit", l_hit, 0);

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == OP_PUT && $urandom_range(0, 1) == 1) op = OP_PUT;
            do_op(op, 16'($urandom_range(1, 7)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge sys_clk); #1;
            end
            if (n == 200) do_reset();
        end

        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); #1;
        end
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/keyvalue_scan.md
# keyvalue_scan

Parametrised associative key/value store behind a pipelined Wishbone-style slave port.
- Keys are searched by linear scan, one entry per cycle; no address-indexed access.
- Supports put (insert or update), get, delete and status operations.
- Reports occupancy and full, and optionally evicts entries round-robin when full.
- Sits on the same bus as the existing fixed-size store; software addresses entries by key.

## Interface
- KEY_W, 16, key width in bits
- VAL_W, 16, value and DAT_i/DAT_o width; must be at least clog2(DEPTH+1)
- DEPTH, 8, number of entries; must be 2 or more
- CNT_W, clog2(DEPTH+1), width of COUNT_o
- sys_clk  in  1  single clock; every register updates on the rising edge
- sys_rst  in  1  synchronous, active-high reset
- CYC_i  in  1  bus cycle valid
- STB_i  in  1  strobe
- WE_i  in  1  1 selects PUT (ADR_i[0]=0) or DEL (ADR_i[0]=1); 0 selects GET (ADR_i[0]=0) or STATUS (ADR_i[0]=1)
- ADR_i  in  16  operation select; only bit 0 is used
- KEY_i  in  KEY_W  key operand
- DAT_i  in  VAL_W  value operand for PUT
- STALL_o  out  1  high while busy; request not accepted
- ACK_o  out  1  one-cycle completion pulse
- ERR_o  out  1  valid with ACK_o; PUT refused because the store is full
- HIT_o  out  1  valid with ACK_o; key found (STATUS: mirrors FULL_o)
- DAT_o  out  VAL_W  response data, valid with ACK_o and held until the next ACK
- COUNT_o  out  CNT_W  number of valid entries
- FULL_o  out  1  high when COUNT_o equals DEPTH

## Operation
- Storage: DEPTH entries, each holding {valid, key, value}.
- On reset:
  - every valid bit, key and value is cleared; count and the round-robin pointer are set to 0
  - outputs: STALL_o, ACK_o, ERR_o, HIT_o and FULL_o are 0; DAT_o and COUNT_o are 0
  - the FSM goes to IDLE
- IDLE (STALL_o=0): when CYC_i and STB_i are both high, latch the operation, KEY_i and DAT_i.
  - STATUS goes to EXEC.
  - All other operations go to SCAN with idx=0 and the first-free tracker cleared.
- SCAN (STALL_o=1): compare entry idx against the latched key.
  - Valid entry with matching key: record idx as a hit and go to EXEC.
  - Otherwise: record the lowest invalid index seen, then increment idx.
  - idx=DEPTH-1 with no match: go to EXEC as a miss.
  - CYC_i low: abort to IDLE with no ACK and no storage change.
- EXEC (STALL_o=1): commit the operation, load ERR_o/HIT_o/DAT_o, go to ACK. CYC_i is ignored from this state on.
  - PUT hit: overwrite the value. DAT_o=slot, HIT_o=1.
  - PUT miss with a free slot: write the lowest free slot, set valid, count+1. DAT_o=slot, HIT_o=0.
  - PUT miss when full: behaviour is set by the macro (see Configuration).
  - GET hit: DAT_o=value, HIT_o=1. GET miss: DAT_o=0, HIT_o=0.
  - DEL hit: clear valid, count-1. DAT_o=old value, HIT_o=1. DEL miss: DAT_o=0, HIT_o=0.
  - STATUS: DAT_o=count, HIT_o=FULL_o.
  - ERR_o is 0 in every case except a refused PUT.
  - Slot indices and count are zero-extended to VAL_W.
- ACK (STALL_o=1): ACK_o=1 for this one cycle, then return to IDLE.
- Requests presented while STALL_o=1 are ignored; the master must hold them.
- sys_rst in any state returns to IDLE, clears all storage, and produces no ACK.

## Timing
- Cycle 0 is the acceptance cycle in IDLE; SCAN checks entry i in cycle 1+i.
- ACK_o:
  - STATUS: cycle 2
  - hit at slot i: cycle 3+i
  - miss: cycle DEPTH+2
- COUNT_o and FULL_o change in the cycle after EXEC, i.e. the same cycle ACK_o rises.
- Back-to-back: the next request can be accepted in the cycle after ACK_o.
- All outputs are registered; FULL_o is decoded from the count register.

## Configuration
- KEYVALUE_EVICT_EN defined: a PUT miss when full overwrites the slot at the round-robin pointer.
  - The pointer then advances, wrapping from DEPTH-1 to 0; count is unchanged.
  - Response: DAT_o=slot, HIT_o=0, ERR_o=0.
- KEYVALUE_EVICT_EN undefined: a PUT miss when full leaves storage unchanged.
  - Response: ERR_o=1, HIT_o=0, DAT_o=0.
  - The round-robin pointer logic is absent.

## Test plan
All scenarios use DEPTH=4.
- Reset, then STATUS -> ACK_o in cycle 2; DAT_o=0, HIT_o=0, COUNT_o=0.
- PUT key 0x00AA with value 0x1234 -> DAT_o=0, HIT_o=0, COUNT_o=1. Then GET 0x00AA -> ACK in cycle 3, DAT_o=0x1234, HIT_o=1.
- PUT key 0x00AA with value 0x5678 -> HIT_o=1, DAT_o=0, COUNT_o stays 1. GET 0x00AA -> 0x5678. GET 0x0BAD -> ACK in cycle 6, HIT_o=0, DAT_o=0.
- Fill keys 1..4, then PUT key 5:
  - macro undefined -> ERR_o=1, COUNT_o=4, FULL_o=1
  - macro defined -> DAT_o=0 and GET 1 misses; a second new key lands in slot 1
- DEL key 2 (slot 1) -> DAT_o=old value, HIT_o=1, COUNT_o=3. PUT key 9 -> DAT_o=1.
- Abort and reset:
  - GET key 4 with CYC_i dropped in cycle 2 -> no ACK_o, STALL_o=0 in the following cycle.
  - sys_rst asserted mid-SCAN -> no ACK_o, COUNT_o=0, and a following GET misses.
